// File: rtl/mdic_ctrl_pkg.sv
// Shared MDIO/MDIC definitions: opcodes, turnaround codes, MDIC bit positions,
// controller states and the clause-22 frame builder.
package mdic_ctrl_pkg;

    localparam logic [1:0] MDIO_OP_WR = 2'b01;
    localparam logic [1:0] MDIO_OP_RD = 2'b10;
    localparam logic [1:0] MDIO_ST    = 2'b01;
    localparam logic [1:0] TA_WR      = 2'b10;
    localparam logic [1:0] TA_RD      = 2'b11;

    localparam int unsigned MDIC_R = 28;
    localparam int unsigned MDIC_I = 29;
    localparam int unsigned MDIC_E = 30;

    typedef enum logic [4:0] {
        ST_IDLE       = 5'b00001,
        ST_LAUNCH     = 5'b00010,
        ST_WAIT_START = 5'b00100,
        ST_WAIT_DONE  = 5'b01000,
        ST_COMPLETE   = 5'b10000
    } mdic_state_e;

    // Reads drive all-ones in the data slot so the PHY can own the line.
    function automatic logic [31:0] build_frame(input logic [1:0]  op,
                                                input logic [4:0]  phy,
                                                input logic [4:0]  regad,
                                                input logic [15:0] data);
        if (op == MDIO_OP_RD)
            return {MDIO_ST, op, phy, regad, TA_RD, 16'hFFFF};
        return {MDIO_ST, op, phy, regad, TA_WR, data};
    endfunction

endpackage

// File: rtl/mdic_ctrl.sv
// Host-side MDIC register: launches clause-22 frames to the MDIO shifter,
// tracks its done flags with a timeout, and reports ready/error/interrupt.
module mdic_ctrl
    import mdic_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 65536,
    parameter int unsigned CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdic_we,
    input  logic [31:0] mdic_wdata,
    output logic [31:0] mdic_rdata,
    output logic        mdic_irq,
    output logic        mdio_en,
    output logic [31:0] mdio_frame,
    input  logic [15:0] mdio_rdata,
    input  logic        mdio_rd_done,
    input  logic        mdio_wr_done
);

    mdic_state_e      state_q, state_d;
    logic [15:0]      data_q;
    logic [4:0]       regad_q, phy_q;
    logic [1:0]       op_q;
    logic             r_q, i_q, e_q, irq_q, en_q, tmo_q;
    logic [31:0]      frame_q;
    logic [CNT_W-1:0] cnt_q;

    logic [1:0] wr_op;
    logic       wr_good, accept, done_sel, waiting, cnt_hit, rd_capture, timeout;
    logic       unused_wdata;

    assign wr_op        = mdic_wdata[27:26];
    assign wr_good      = (wr_op == MDIO_OP_WR) || (wr_op == MDIO_OP_RD);
    assign unused_wdata = ^{mdic_wdata[31:30], mdic_wdata[28]};

    // Matching one short of the limit puts R=1 exactly TIMEOUT_CYC cycles after the enable pulse.
    assign cnt_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        accept     = 1'b0;
        waiting    = 1'b0;
        rd_capture = 1'b0;
        timeout    = 1'b0;
        done_sel   = (op_q == MDIO_OP_RD) ? mdio_rd_done : mdio_wr_done;
        unique case (state_q)
            ST_IDLE: begin
                accept = mdic_we;
                if (mdic_we && wr_good) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: state_d = ST_WAIT_START;
            ST_WAIT_START: begin
                waiting = 1'b1;
                if (cnt_hit) begin
                    timeout = 1'b1;
                    state_d = ST_COMPLETE;
                end else if (!done_sel) begin
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                waiting = 1'b1;
                if (done_sel) begin
                    rd_capture = (op_q == MDIO_OP_RD);
                    state_d    = ST_COMPLETE;
                end else if (cnt_hit) begin
                    timeout = 1'b1;
                    state_d = ST_COMPLETE;
                end
            end
            ST_COMPLETE: state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            regad_q <= '0;
            phy_q   <= '0;
            op_q    <= '0;
            r_q     <= 1'b1;
            i_q     <= 1'b0;
            e_q     <= 1'b0;
            irq_q   <= 1'b0;
            en_q    <= 1'b0;
            tmo_q   <= 1'b0;
            frame_q <= '0;
            cnt_q   <= '0;
        end else begin
            irq_q <= 1'b0;
            en_q  <= 1'b0;
            if (accept) begin
                data_q  <= mdic_wdata[15:0];
                regad_q <= mdic_wdata[20:16];
                phy_q   <= mdic_wdata[25:21];
                op_q    <= wr_op;
                i_q     <= mdic_wdata[MDIC_I];
                if (wr_good) begin
                    r_q     <= 1'b0;
                    e_q     <= 1'b0;
                    frame_q <= build_frame(wr_op, mdic_wdata[25:21],
                                           mdic_wdata[20:16], mdic_wdata[15:0]);
                end else begin
                    r_q   <= 1'b1;
                    e_q   <= 1'b1;
                    irq_q <= mdic_wdata[MDIC_I];
                end
            end
            if (state_q == ST_LAUNCH) begin
                en_q  <= 1'b1;
                cnt_q <= '0;
                tmo_q <= 1'b0;
            end
            if (waiting && !cnt_hit) cnt_q <= cnt_q + CNT_W'(1);
            if (timeout)             tmo_q <= 1'b1;
            if (rd_capture)          data_q <= mdio_rdata;
            if (state_q == ST_COMPLETE) begin
                r_q   <= 1'b1;
                e_q   <= tmo_q;
                irq_q <= i_q;
            end
        end
    end

    assign mdic_rdata = {1'b0, e_q, i_q, r_q, op_q, phy_q, regad_q, data_q};
    assign mdic_irq   = irq_q;
    assign mdio_en    = en_q;
    assign mdio_frame = frame_q;

endmodule

// File: tb/tb_mdic_ctrl.sv
// Self-checking bench for mdic_ctrl with a behavioural MDIO shifter responder.
module tb_mdic_ctrl;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mdic_we;
    logic [31:0] mdic_wdata;
    logic [31:0] mdic_rdata;
    logic        mdic_irq;
    logic        mdio_en;
    logic [31:0] mdio_frame;
    logic [15:0] mdio_rdata;
    logic        mdio_rd_done;
    logic        mdio_wr_done;

    mdic_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(7)) dut (
        .clk(clk), .rst_n(rst_n), .mdic_we(mdic_we), .mdic_wdata(mdic_wdata),
        .mdic_rdata(mdic_rdata), .mdic_irq(mdic_irq), .mdio_en(mdio_en),
        .mdio_frame(mdio_frame), .mdio_rdata(mdio_rdata),
        .mdio_rd_done(mdio_rd_done), .mdio_wr_done(mdio_wr_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] wdata;
        logic [15:0] rd_val;
        logic        good;
        logic [31:0] frame;
        logic [31:0] rdata;
        logic        irq;
    } vec_t;

    vec_t vecs[6];
    vec_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int en_cnt = 0, irq_cnt = 0, en_cyc = 0, rise_cyc = 0;
    logic [31:0] last_frame = '0;

    logic        resp_on = 1'b1, abort = 1'b0, resp_rd;
    int          resp_dly = 3, resp_len = 5;
    logic [15:0] resp_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mdio_en) begin
            en_cnt++;
            en_cyc     = cyc;
            last_frame = mdio_frame;
        end
        if (mdic_irq) irq_cnt++;
    end

    initial begin
        mdio_rd_done = 1'b1;
        mdio_wr_done = 1'b1;
        mdio_rdata   = '0;
        forever begin
            @(negedge clk);
            if (mdio_en && resp_on) begin
                resp_rd = (mdio_frame[29:28] == 2'b10);
                for (int i = 0; i < resp_dly && !abort; i++) @(negedge clk);
                if (resp_rd) mdio_rd_done = 1'b0;
                else         mdio_wr_done = 1'b0;
                for (int i = 0; i < resp_len && !abort; i++) @(negedge clk);
                mdio_rdata   = resp_val;
                mdio_rd_done = 1'b1;
                mdio_wr_done = 1'b1;
                rise_cyc     = cyc;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic wait_r(output int rc);
        int n = 0;
        while (!mdic_rdata[28] && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!mdic_rdata[28]) begin
            checks++;
            errors++;
            $display("FAIL wait_R actual=R0 expected=R1 within 300 cycles");
        end
        rc = cyc;
    endtask

    task automatic issue(input logic [31:0] w, output int wc);
        @(negedge clk);
        mdic_wdata = w;
        mdic_we    = 1'b1;
        wc         = cyc;
        @(negedge clk);
        mdic_we = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int e0, i0, wc, rc;
        vec_t x;
        e0 = en_cnt;
        i0 = irq_cnt;
        resp_val = v.rd_val;
        issue(v.wdata, wc);
        sb.push_back(v);
        if (v.good) chk("busy_rdata", mdic_rdata, {2'b00, v.wdata[29], 1'b0, v.wdata[27:0]});
        else        chk("badop_next_cycle", mdic_rdata, v.rdata);
        wait_r(rc);
        x = sb.pop_front();
        chk("final_rdata", mdic_rdata, x.rdata);
        if (x.good) begin
            chk("frame", last_frame, x.frame);
            chk("we_to_en", 32'(en_cyc - wc), 32'd2);
            chk("done_to_R", 32'(rc - rise_cyc), 32'd2);
        end
        repeat (3) @(negedge clk);
        chk("en_pulses", 32'(en_cnt - e0), x.good ? 32'd1 : 32'd0);
        chk("irq_pulses", 32'(irq_cnt - i0), {31'd0, x.irq});
    endtask

    initial begin
        int wc, rc, e0, n;
        vecs[0] = '{32'h0422_1140, 16'h0000, 1'b1, 32'h508A_1140, 32'h1422_1140, 1'b0};
        vecs[1] = '{32'h2821_0000, 16'h796D, 1'b1, 32'h6087_FFFF, 32'h3821_796D, 1'b1};
        vecs[2] = '{32'h27FF_A5A5, 16'h0000, 1'b1, 32'h5FFE_A5A5, 32'h37FF_A5A5, 1'b1};
        vecs[3] = '{32'h0800_1234, 16'hBEEF, 1'b1, 32'h6003_FFFF, 32'h1800_BEEF, 1'b0};
        vecs[4] = '{32'h2000_5555, 16'h0000, 1'b0, 32'h0000_0000, 32'h7000_5555, 1'b1};
        vecs[5] = '{32'h0C00_0000, 16'h0000, 1'b0, 32'h0000_0000, 32'h5C00_0000, 1'b0};

        rst_n = 1'b0; mdic_we = 1'b0; mdic_wdata = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rdata", mdic_rdata, 32'h1000_0000);
        chk("reset_irq", {31'd0, mdic_irq}, 32'd0);
        chk("reset_en", {31'd0, mdio_en}, 32'd0);
        chk("reset_frame", mdio_frame, 32'd0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Timeout: shifter never responds, read data must stay as written.
        resp_on = 1'b0;
        e0 = en_cnt;
        issue(32'h0841_1234, wc);
        wait_r(rc);
        chk("timeout_rdata", mdic_rdata, 32'h5841_1234);
        chk("timeout_latency", 32'(rc - en_cyc), 32'(TMO));
        chk("timeout_en_pulses", 32'(en_cnt - e0), 32'd1);
        resp_on = 1'b1;
        repeat (2) @(negedge clk);

        // Busy write during WAIT_DONE is ignored.
        resp_dly = 2; resp_len = 20; resp_val = 16'hC0DE;
        e0 = en_cnt;
        issue(32'h0821_0000, wc);
        n = 0;
        while (mdio_rd_done && n < 50) begin @(negedge clk); n++; end
        chk("busy_rd_low", {31'd0, mdio_rd_done}, 32'd0);
        repeat (2) @(negedge clk);
        issue(32'h0BE1_0000, wc);
        chk("busy_frame", mdio_frame, 32'h6087_FFFF);
        chk("busy_fields", mdic_rdata, 32'h0821_0000);
        wait_r(rc);
        chk("busy_final", mdic_rdata, 32'h1821_C0DE);
        repeat (3) @(negedge clk);
        chk("busy_en_pulses", 32'(en_cnt - e0), 32'd1);

        // Asynchronous reset mid-transaction, then a normal command.
        issue(32'h0422_1140, wc);
        n = 0;
        while (mdio_wr_done && n < 50) begin @(negedge clk); n++; end
        chk("rst_wr_low", {31'd0, mdio_wr_done}, 32'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_rdata", mdic_rdata, 32'h1000_0000);
        chk("midrst_en", {31'd0, mdio_en}, 32'd0);
        chk("midrst_frame", mdio_frame, 32'd0);
        abort = 1'b1;
        repeat (3) @(negedge clk);
        abort = 1'b0;
        rst_n = 1'b1;
        resp_dly = 3; resp_len = 5;
        @(negedge clk);
        run_vec(vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1);
    end

endmodule
